// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the width-down FIFO: output-mode encodings and
// pointer/count width helpers used by the interface, top and control block.
package sync_fifo_pkg;

  localparam int OUT_COMB = 0;
  localparam int OUT_REG  = 1;

  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

  // One extra bit so a completely full FIFO (count == depth) is representable.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/sync_fifo_w2n_if.sv
// Handshake bundle for sync_fifo_w2n. Optional error flags appear when
// SYNC_FIFO_W2N_ERR_EN is defined.
interface sync_fifo_w2n_if
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH_O = 64,
  parameter int RATIO        = 4,
  parameter int FIFO_DEPTH   = 16
);

  localparam int CNT_W = cnt_width(FIFO_DEPTH);

  logic                            fifo_wr;
  logic [RATIO*DATA_WIDTH_O-1:0]   fifo_din;
  logic                            fifo_full;
  logic                            fifo_afull;
  logic                            fifo_rd;
  logic [DATA_WIDTH_O-1:0]         fifo_dout;
  logic                            fifo_empty;
  logic                            fifo_aempty;
  logic [CNT_W-1:0]                fifo_cnt;
`ifdef SYNC_FIFO_W2N_ERR_EN
  logic                            fifo_ovf;
  logic                            fifo_udf;

  modport master (
    output fifo_wr, fifo_din, fifo_rd,
    input  fifo_full, fifo_afull, fifo_dout, fifo_empty, fifo_aempty, fifo_cnt,
    input  fifo_ovf, fifo_udf
  );

  modport slave (
    input  fifo_wr, fifo_din, fifo_rd,
    output fifo_full, fifo_afull, fifo_dout, fifo_empty, fifo_aempty, fifo_cnt,
    output fifo_ovf, fifo_udf
  );
`else
  modport master (
    output fifo_wr, fifo_din, fifo_rd,
    input  fifo_full, fifo_afull, fifo_dout, fifo_empty, fifo_aempty, fifo_cnt
  );

  modport slave (
    input  fifo_wr, fifo_din, fifo_rd,
    output fifo_full, fifo_afull, fifo_dout, fifo_empty, fifo_aempty, fifo_cnt
  );
`endif

endinterface

// File: rtl/sync_fifo_w2n_ctrl.sv
// Pointer, occupancy and flag logic for sync_fifo_w2n. Sticky overflow/underflow
// flags exist only when SYNC_FIFO_W2N_ERR_EN is defined.
module sync_fifo_w2n_ctrl
  import sync_fifo_pkg::*;
#(
  parameter int RATIO      = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int AFULL_TH   = 12,
  parameter int AEMPTY_TH  = 2,
  localparam int ADDR_W    = ptr_width(FIFO_DEPTH),
  localparam int CNT_W     = cnt_width(FIFO_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_wr,
  input  logic              fifo_rd,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic [ADDR_W-1:0] rd_ptr,
  output logic              wr_acc,
  output logic              rd_acc,
  output logic [CNT_W-1:0]  fifo_cnt,
  output logic              fifo_full,
  output logic              fifo_afull,
  output logic              fifo_empty,
  output logic              fifo_aempty
`ifdef SYNC_FIFO_W2N_ERR_EN
  ,
  output logic              fifo_ovf,
  output logic              fifo_udf
`endif
);

  logic [CNT_W-1:0] cnt_next;

  // Flags look only at the registered count, so a same-cycle read never
  // frees room for a write and a same-cycle write never feeds a read.
  assign fifo_full   = (fifo_cnt >  CNT_W'(FIFO_DEPTH - RATIO));
  assign fifo_empty  = (fifo_cnt == '0);
  assign fifo_afull  = (fifo_cnt >= CNT_W'(AFULL_TH));
  assign fifo_aempty = (fifo_cnt <= CNT_W'(AEMPTY_TH));

  assign wr_acc = fifo_wr & ~fifo_full;
  assign rd_acc = fifo_rd & ~fifo_empty;

  assign cnt_next = fifo_cnt
                  + (wr_acc ? CNT_W'(RATIO) : '0)
                  - (rd_acc ? CNT_W'(1)     : '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ADDR_W'(RATIO);
      if (rd_acc) rd_ptr <= rd_ptr + ADDR_W'(1);
      fifo_cnt <= cnt_next;
    end
  end

`ifdef SYNC_FIFO_W2N_ERR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_ovf <= 1'b0;
      fifo_udf <= 1'b0;
    end else begin
      if (fifo_wr & fifo_full)  fifo_ovf <= 1'b1;
      if (fifo_rd & fifo_empty) fifo_udf <= 1'b1;
    end
  end
`endif

endmodule

// File: rtl/sync_fifo_w2n.sv
// Width-down synchronous FIFO: RATIO lanes in per write, one lane out per read,
// lane 0 first. Define SYNC_FIFO_W2N_ERR_EN for sticky overflow/underflow flags.
module sync_fifo_w2n
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH_O = 64,
  parameter int RATIO        = 4,
  parameter int FIFO_DEPTH   = 16,
  parameter int OUTPUT_MODE  = OUT_COMB,
  parameter int AFULL_TH     = 12,
  parameter int AEMPTY_TH    = 2
) (
  input  logic          clk,
  input  logic          rst,
  sync_fifo_w2n_if.slave bus
);

  localparam int ADDR_W = ptr_width(FIFO_DEPTH);

  if (!is_pow2(RATIO) || RATIO < 2 || !is_pow2(FIFO_DEPTH) ||
      (FIFO_DEPTH % RATIO) != 0 || FIFO_DEPTH < 2 * RATIO) begin : g_bad_cfg
    $error("sync_fifo_w2n: RATIO and FIFO_DEPTH must be powers of 2, RATIO >= 2, FIFO_DEPTH a multiple of RATIO and >= 2*RATIO");
  end

  logic [ADDR_W-1:0]       wr_ptr;
  logic [ADDR_W-1:0]       rd_ptr;
  logic                    wr_acc;
  logic                    rd_acc;
  logic [DATA_WIDTH_O-1:0] mem [FIFO_DEPTH];
  logic [DATA_WIDTH_O-1:0] dout_p1;

  sync_fifo_w2n_ctrl #(
    .RATIO      (RATIO),
    .FIFO_DEPTH (FIFO_DEPTH),
    .AFULL_TH   (AFULL_TH),
    .AEMPTY_TH  (AEMPTY_TH)
  ) u_ctrl (
    .clk         (clk),
    .rst         (rst),
    .fifo_wr     (bus.fifo_wr),
    .fifo_rd     (bus.fifo_rd),
    .wr_ptr      (wr_ptr),
    .rd_ptr      (rd_ptr),
    .wr_acc      (wr_acc),
    .rd_acc      (rd_acc),
    .fifo_cnt    (bus.fifo_cnt),
    .fifo_full   (bus.fifo_full),
    .fifo_afull  (bus.fifo_afull),
    .fifo_empty  (bus.fifo_empty),
    .fifo_aempty (bus.fifo_aempty)
`ifdef SYNC_FIFO_W2N_ERR_EN
    ,
    .fifo_ovf    (bus.fifo_ovf),
    .fifo_udf    (bus.fifo_udf)
`endif
  );

  // wr_ptr is RATIO-aligned, so the lanes of one write never straddle the wrap.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      for (int k = 0; k < RATIO; k++) begin
        mem[wr_ptr + ADDR_W'(k)] <= bus.fifo_din[k*DATA_WIDTH_O +: DATA_WIDTH_O];
      end
    end
  end

  // Registered read stage: head slice captured on an accepted read
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_p1 <= '0;
    end else if (rd_acc) begin
      dout_p1 <= mem[rd_ptr];
    end
  end

  assign bus.fifo_dout = (OUTPUT_MODE == OUT_REG) ? dout_p1 : mem[rd_ptr];

endmodule

// File: tb/tb_sync_fifo_w2n.sv
// Scoreboard bench for sync_fifo_w2n: one combinational-output and one
// registered-output instance driven in lockstep against a queue-of-slices model.
module tb_sync_fifo_w2n;
  import sync_fifo_pkg::*;

  localparam int DW = 64;
  localparam int R  = 4;
  localparam int D  = 16;
  localparam int AF = 12;
  localparam int AE = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sync_fifo_w2n_if #(.DATA_WIDTH_O(DW), .RATIO(R), .FIFO_DEPTH(D)) bus0 ();
  sync_fifo_w2n_if #(.DATA_WIDTH_O(DW), .RATIO(R), .FIFO_DEPTH(D)) bus1 ();

  sync_fifo_w2n #(
    .DATA_WIDTH_O(DW), .RATIO(R), .FIFO_DEPTH(D),
    .OUTPUT_MODE(OUT_COMB), .AFULL_TH(AF), .AEMPTY_TH(AE)
  ) dut0 (.clk(clk), .rst(rst), .bus(bus0));

  sync_fifo_w2n #(
    .DATA_WIDTH_O(DW), .RATIO(R), .FIFO_DEPTH(D),
    .OUTPUT_MODE(OUT_REG), .AFULL_TH(AF), .AEMPTY_TH(AE)
  ) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  logic [DW-1:0] model_q[$];
  logic [DW-1:0] exp0_q[$];
  logic [DW-1:0] exp1_q[$];
  logic [DW-1:0] hold1;
  bit            pend1;
  bit            exp_ovf;
  bit            exp_udf;
  bit            mon_en;
  int            n_cmp;
  int            n_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_flags(input string tag, input logic [4:0] cnt, input logic full,
                           input logic afull, input logic empty, input logic aempty);
    int c;
    c = model_q.size();
    chk({tag, "_cnt"},    64'(cnt),    64'(c));
    chk({tag, "_full"},   64'(full),   64'(c > D - R));
    chk({tag, "_afull"},  64'(afull),  64'(c >= AF));
    chk({tag, "_empty"},  64'(empty),  64'(c == 0));
    chk({tag, "_aempty"}, 64'(aempty), 64'(c <= AE));
  endtask

  // Monitor: samples on the falling edge, well away from the active edge.
  always @(negedge clk) begin
    if (mon_en) begin
      chk_flags("m0", bus0.fifo_cnt, bus0.fifo_full, bus0.fifo_afull, bus0.fifo_empty, bus0.fifo_aempty);
      chk_flags("m1", bus1.fifo_cnt, bus1.fifo_full, bus1.fifo_afull, bus1.fifo_empty, bus1.fifo_aempty);
`ifdef SYNC_FIFO_W2N_ERR_EN
      chk("ovf0", 64'(bus0.fifo_ovf), 64'(exp_ovf));
      chk("udf0", 64'(bus0.fifo_udf), 64'(exp_udf));
`endif
      if (bus0.fifo_rd && !bus0.fifo_empty) begin
        if (exp0_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL dout0: read accepted with data %0h, expected no read", bus0.fifo_dout);
        end else begin
          chk("dout0", 64'(bus0.fifo_dout), 64'(exp0_q.pop_front()));
        end
      end
      if (pend1) begin
        if (exp1_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL dout1: read accepted with data %0h, expected no read", bus1.fifo_dout);
        end else begin
          hold1 = exp1_q.pop_front();
        end
      end
      chk("dout1", 64'(bus1.fifo_dout), 64'(hold1));
      pend1 = bus1.fifo_rd && !bus1.fifo_empty;
    end
  end

  task automatic drive(input bit wr, input logic [R*DW-1:0] din, input bit rd);
    bus0.fifo_wr = wr; bus0.fifo_din = din; bus0.fifo_rd = rd;
    bus1.fifo_wr = wr; bus1.fifo_din = din; bus1.fifo_rd = rd;
  endtask

  // One clock of stimulus; the model applies the acceptance rules directly.
  task automatic step(input bit wr, input logic [R*DW-1:0] din, input bit rd);
    bit wacc, racc;
    drive(wr, din, rd);
    wacc = wr && !(model_q.size() > D - R);
    racc = rd && (model_q.size() != 0);
    if (racc) begin
      exp0_q.push_back(model_q[0]);
      exp1_q.push_back(model_q[0]);
    end
    @(posedge clk);
    if (wr && !wacc) exp_ovf = 1'b1;
    if (rd && !racc) exp_udf = 1'b1;
    if (racc) void'(model_q.pop_front());
    if (wacc) for (int k = 0; k < R; k++) model_q.push_back(din[k*DW +: DW]);
    #1;
  endtask

  task automatic do_reset(input bit wr, input logic [R*DW-1:0] din);
    rst = 1'b1;
    drive(wr, din, 1'b0);
    @(posedge clk);
    model_q.delete(); exp0_q.delete(); exp1_q.delete();
    exp_ovf = 1'b0; exp_udf = 1'b0; hold1 = '0; pend1 = 1'b0;
    #1;
    rst = 1'b0;
    drive(1'b0, '0, 1'b0);
    mon_en = 1'b1;
  endtask

  function automatic logic [R*DW-1:0] rand_wide();
    logic [R*DW-1:0] w;
    for (int k = 0; k < R*DW/32; k++) w[k*32 +: 32] = $urandom;
    return w;
  endfunction

  function automatic logic [R*DW-1:0] lanes(input int base);
    logic [R*DW-1:0] w;
    for (int k = 0; k < R; k++) w[k*DW +: DW] = DW'(base + k);
    return w;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0; n_err = 0; mon_en = 1'b0; pend1 = 1'b0; hold1 = '0;
    exp_ovf = 1'b0; exp_udf = 1'b0;
    drive(1'b0, '0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    do_reset(1'b0, '0);
    step(1'b0, '0, 1'b0);

    // Single write of lanes 1..4 then four reads.
    step(1'b1, {64'd4, 64'd3, 64'd2, 64'd1}, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);

    // Fill, overflow attempt, then same-cycle write+read at 13 and 12.
    for (int i = 0; i < 5; i++) step(1'b1, lanes(16 * i + 16), 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
    step(1'b1, lanes(200), 1'b1);
    step(1'b1, lanes(300), 1'b1);
    for (int i = 0; i < 16; i++) step(1'b0, '0, 1'b1);

    // Read while empty together with a write.
    do_reset(1'b0, '0);
    step(1'b1, lanes(400), 1'b1);
    step(1'b0, '0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);

    // Reset with occupancy 8 and a concurrent write, then fresh ordering.
    do_reset(1'b0, '0);
    step(1'b1, lanes(500), 1'b0);
    step(1'b1, lanes(600), 1'b0);
    do_reset(1'b1, lanes(700));
    step(1'b0, '0, 1'b0);
    step(1'b1, lanes(800), 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);

    // Random stream across many pointer wraps.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) == 0, rand_wide(), $urandom_range(0, 3) != 0);
    for (int i = 0; i < 2 * D && model_q.size() != 0; i++) step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    chk("drained_model", 64'(model_q.size()), 64'd0);
    chk("sb0_left", 64'(exp0_q.size()), 64'd0);
    chk("sb1_left", 64'(exp1_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sync_fifo_w2n.md
Name: sync_fifo_w2n

Overview:
- Parametrised synchronous width-down FIFO.
- Accepts one wide word of RATIO x DATA_WIDTH_O bits per write and returns DATA_WIDTH_O-bit slices per read, least-significant lane first.
- Next-generation replacement for the fixed 256-to-64 buffer in the memory-control datapath. Adds:
  - generic ratio and depth;
  - exact full/empty with protection against overflow and underflow;
  - occupancy output;
  - almost-full and almost-empty thresholds.

Parameters:
- DATA_WIDTH_O, 64, output slice width in bits.
- RATIO, 4, input-to-output width ratio; power of 2, >= 2.
- FIFO_DEPTH, 16, capacity in output slices; power of 2, multiple of RATIO, >= 2*RATIO.
- OUTPUT_MODE, 0, 0 = combinational head output, 1 = registered output updated on an accepted read.
- AFULL_TH, 12, fifo_afull asserts when fifo_cnt >= AFULL_TH.
- AEMPTY_TH, 2, fifo_aempty asserts when fifo_cnt <= AEMPTY_TH.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- fifo_wr  in  1  write request.
- fifo_din  in  RATIO*DATA_WIDTH_O  wide write data; lane k = bits [k*DATA_WIDTH_O +: DATA_WIDTH_O].
- fifo_full  out  1  high when fewer than RATIO slots are free.
- fifo_afull  out  1  almost full.
- fifo_rd  in  1  read request.
- fifo_dout  out  DATA_WIDTH_O  read data.
- fifo_empty  out  1  high when fifo_cnt == 0.
- fifo_aempty  out  1  almost empty.
- fifo_cnt  out  $clog2(FIFO_DEPTH)+1  occupancy in slices.

Behaviour:
- ADDR_W = $clog2(FIFO_DEPTH).
- Pointers: wr_ptr and rd_ptr are ADDR_W bits wide and wrap naturally.
- Write side:
  - wr_ptr always stays a multiple of RATIO.
  - Accepted write: wr_acc = fifo_wr & ~fifo_full. It stores lane k at mem[wr_ptr+k] and advances wr_ptr by RATIO.
- Read side:
  - Accepted read: rd_acc = fifo_rd & ~fifo_empty. It advances rd_ptr by 1.
- Rejected requests: a write while full or a read while empty is ignored. Pointers, count and memory do not change.
- Flag timing:
  - fifo_full and fifo_empty come from the registered fifo_cnt only.
  - A read in the same cycle does not allow a write when full. A write in the same cycle does not allow a read when empty. There is no bypass path.
- Count update: fifo_cnt_next = fifo_cnt + (wr_acc ? RATIO : 0) - (rd_acc ? 1 : 0). Compute it at ADDR_W+1 bits; it never exceeds FIFO_DEPTH.
- Flag definitions: fifo_full = (fifo_cnt > FIFO_DEPTH-RATIO). fifo_afull and fifo_aempty are combinational from fifo_cnt.
- Output, OUTPUT_MODE 0: fifo_dout = mem[rd_ptr] at all times; its value is undefined while empty.
- Output, OUTPUT_MODE 1: on rd_acc, fifo_dout <= mem[rd_ptr], giving 1-cycle read latency. Otherwise fifo_dout holds its value.
- Memory: no reset on the memory array.
- Reset values: rd_ptr=0, wr_ptr=0, fifo_cnt=0, fifo_empty=1, fifo_full=0, fifo_afull=0, fifo_aempty=1, registered fifo_dout=0.
- Reset mid-operation: reset wins over any concurrent request. Stored data is discarded logically.
- Elaboration checks: FIFO_DEPTH % RATIO != 0, or a non-power-of-2 RATIO or FIFO_DEPTH, must produce a $error.

Optional Feature:
- Macro: SYNC_FIFO_W2N_ERR_EN.
- When defined, two extra outputs exist:
  - fifo_ovf (1): sticky; set on fifo_wr & fifo_full.
  - fifo_udf (1): sticky; set on fifo_rd & fifo_empty.
- Both flags reset to 0 and clear only on rst.
- When undefined, the ports and logic are absent and rejected requests are silently dropped.

Decomposition:
- Shared package sync_fifo_pkg:
  - localparam helper function for pointer/count width;
  - OUTPUT_MODE encodings OUT_COMB=0, OUT_REG=1.
- One sub-module: sync_fifo_w2n_ctrl, holding pointers, fifo_cnt and flag logic.
- Top level holds the memory array, lane slicing and the output register.

Test Plan:
- Reset then a single write of lanes {4,3,2,1} (lane0=1), then 4 reads: dout sequence 1,2,3,4. fifo_cnt goes 4,3,2,1,0 and fifo_empty returns to 1.
- Fill with default params, 4 writes: fifo_cnt=16, fifo_full=1, fifo_afull=1. A 5th write is ignored and fifo_cnt stays 16. With ERR_EN, fifo_ovf=1.
- At fifo_cnt=13, simultaneous fifo_wr+fifo_rd: write rejected, read accepted, fifo_cnt=12. At fifo_cnt=12, the same pair gives fifo_cnt=15.
- Wrap-around: 20 writes interleaved with 70 reads in steady stream. The data order is preserved across pointer wrap and no slice is lost or duplicated.
- Read while empty in the same cycle as a write: read ignored, fifo_cnt=4 next cycle, fifo_dout in OUTPUT_MODE 1 unchanged.
- Assert rst while fifo_cnt=8 with fifo_wr=1: next cycle fifo_cnt=0, fifo_empty=1 and all pointers are 0.
